// File: rtl/fifo_construct.sv
// Narrow-to-wide width converter: packs NSIZE beats of DSIZE bits into one word,
// first beat in the most-significant slice, with early close via wr_last.
module fifo_construct #(
    parameter int DSIZE = 1,
    parameter int NSIZE = 8,
    parameter int RSIZE = (NSIZE < 16) ? 4 :
                          (NSIZE < 32) ? 5 :
                          (NSIZE < 64) ? 6 :
                          (NSIZE < 128) ? 7 : 8
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [DSIZE-1:0]       wr_data,
    input  logic                   wr_vld,
    input  logic                   wr_last,
    output logic                   wr_ready,
    output logic [DSIZE*NSIZE-1:0] rd_data,
    output logic [RSIZE-1:0]       rd_cnt,
    output logic                   rd_vld,
    input  logic                   rd_ready
);

    localparam int W = DSIZE * NSIZE;

    // Handshake: a beat moves when wr_vld && wr_ready; a word moves when
    // rd_vld && rd_ready. Neither ready depends on the matching valid.
    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     acc, acc_nxt, acc_beat;
    logic [RSIZE-1:0] point, point_nxt;
    logic [RSIZE-1:0] hold_cnt, hold_cnt_nxt;
    logic             accept, complete, drain, out_free;
    logic             load;
    logic [W-1:0]     load_data;
    logic [RSIZE-1:0] load_cnt;

    assign wr_ready = !rst && (state == FILL);
    assign accept   = wr_vld && wr_ready;
    assign complete = accept && (wr_last || (point == RSIZE'(NSIZE - 1)));
    assign drain    = rd_vld && rd_ready;
    assign out_free = !rd_vld || drain;

    // Accumulator with the current beat dropped into the slice selected by point.
    always_comb begin
        acc_beat = acc;
        for (int k = 0; k < NSIZE; k++) begin
            if (point == RSIZE'(k)) begin
                acc_beat[DSIZE*(NSIZE-k)-1 -: DSIZE] = wr_data;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        point_nxt    = point;
        hold_cnt_nxt = hold_cnt;
        load         = 1'b0;
        load_data    = acc;
        load_cnt     = hold_cnt;
        case (state)
            FILL: begin
                if (complete) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = acc_beat;
                        load_cnt  = point + RSIZE'(1);
                        acc_nxt   = '0;
                        point_nxt = '0;
                    end else begin
                        acc_nxt      = acc_beat;
                        hold_cnt_nxt = point + RSIZE'(1);
                        state_nxt    = HOLD;
                    end
                end else if (accept) begin
                    acc_nxt   = acc_beat;
                    point_nxt = point + RSIZE'(1);
                end
            end
            HOLD: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = acc;
                    load_cnt  = hold_cnt;
                    acc_nxt   = '0;
                    point_nxt = '0;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= FILL;
            acc      <= '0;
            point    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            point    <= point_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // A load in the same cycle as a drain keeps rd_vld high with the new word.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_data <= '0;
            rd_cnt  <= '0;
            rd_vld  <= 1'b0;
        end else if (load) begin
            rd_data <= load_data;
            rd_cnt  <= load_cnt;
            rd_vld  <= 1'b1;
        end else if (drain) begin
            rd_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_construct.sv
// Directed bench for fifo_construct with DSIZE=8, NSIZE=4: full words, streaming,
// backpressure/HOLD, early close, drain-while-complete and mid-word reset.
module tb_fifo_construct;

    localparam int DSIZE = 8;
    localparam int NSIZE = 4;
    localparam int RSIZE = 4;

    logic                   clock;
    logic                   rst;
    logic [DSIZE-1:0]       wr_data;
    logic                   wr_vld;
    logic                   wr_last;
    logic                   wr_ready;
    logic [DSIZE*NSIZE-1:0] rd_data;
    logic [RSIZE-1:0]       rd_cnt;
    logic                   rd_vld;
    logic                   rd_ready;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_construct #(.DSIZE(DSIZE), .NSIZE(NSIZE)) dut (
        .clock    (clock),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_vld   (wr_vld),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_cnt   (rd_cnt),
        .rd_vld   (rd_vld),
        .rd_ready (rd_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs settle and outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        wr_data = d;
        wr_vld  = 1'b1;
        wr_last = last;
        cycle();
    endtask

    task automatic idle();
        wr_vld  = 1'b0;
        wr_last = 1'b0;
        cycle();
    endtask

    logic        ready_ok;
    logic [31:0] exp_word;

    initial begin
        rst      = 1'b1;
        wr_data  = '0;
        wr_vld   = 1'b0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        cycle();
        cycle();
        check("reset_wr_ready", 64'(wr_ready), 64'd0);
        check("reset_rd_vld",   64'(rd_vld),   64'd0);
        check("reset_rd_cnt",   64'(rd_cnt),   64'd0);
        check("reset_rd_data",  64'(rd_data),  64'd0);
        rst = 1'b0;
        #1;
        check("post_reset_wr_ready", 64'(wr_ready), 64'd1);

        // Full word, back-to-back beats.
        rd_ready = 1'b1;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        check("full_not_yet_vld", 64'(rd_vld), 64'd0);
        beat(8'h44, 1'b0);
        check("full_vld",      64'(rd_vld),   64'd1);
        check("full_data",     64'(rd_data),  64'h11223344);
        check("full_cnt",      64'(rd_cnt),   64'd4);
        check("full_wr_ready", 64'(wr_ready), 64'd1);
        idle();
        check("full_drained", 64'(rd_vld), 64'd0);

        // Streaming 0x00..0x0F with rd_ready=1: one word every 4 cycles.
        ready_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            wr_vld  = 1'b1;
            wr_last = 1'b0;
            #0;
            if (!wr_ready) ready_ok = 1'b0;
            cycle();
            if (i % 4 == 3) begin
                exp_word = {8'(i-3), 8'(i-2), 8'(i-1), 8'(i)};
                check("stream_vld",  64'(rd_vld),  64'd1);
                check("stream_data", 64'(rd_data), 64'(exp_word));
                check("stream_cnt",  64'(rd_cnt),  64'd4);
            end else begin
                check("stream_gap", 64'(rd_vld), 64'd0);
            end
        end
        check("stream_wr_ready_never_low", 64'(ready_ok), 64'd1);
        idle();

        // Backpressure: two words buffered, then wr_ready drops.
        rd_ready = 1'b0;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        check("bp_vld",  64'(rd_vld),  64'd1);
        check("bp_data", 64'(rd_data), 64'h01020304);
        beat(8'h05, 1'b0);
        beat(8'h06, 1'b0);
        beat(8'h07, 1'b0);
        check("bp_data_stable", 64'(rd_data), 64'h01020304);
        check("bp_ready_before_8", 64'(wr_ready), 64'd1);
        beat(8'h08, 1'b0);
        check("bp_hold_wr_ready", 64'(wr_ready), 64'd0);
        check("bp_hold_data",     64'(rd_data),  64'h01020304);
        beat(8'h09, 1'b1);
        check("bp_stall_wr_ready", 64'(wr_ready), 64'd0);
        check("bp_stall_data",     64'(rd_data),  64'h01020304);
        check("bp_stall_cnt",      64'(rd_cnt),   64'd4);
        rd_ready = 1'b1;
        cycle();
        check("bp_second_data",  64'(rd_data),  64'h05060708);
        check("bp_second_cnt",   64'(rd_cnt),   64'd4);
        check("bp_second_vld",   64'(rd_vld),   64'd1);
        check("bp_refill_ready", 64'(wr_ready), 64'd1);
        cycle();
        check("bp_nine_vld",  64'(rd_vld),  64'd1);
        check("bp_nine_data", 64'(rd_data), 64'h09000000);
        check("bp_nine_cnt",  64'(rd_cnt),  64'd1);
        idle();
        check("bp_drained", 64'(rd_vld), 64'd0);

        // Early close, then next word starts at the MSB slice; wr_last on the final slot.
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        check("early_data", 64'(rd_data), 64'hAABB0000);
        check("early_cnt",  64'(rd_cnt),  64'd2);
        beat(8'hCC, 1'b0);
        check("early_drained", 64'(rd_vld), 64'd0);
        beat(8'hDD, 1'b0);
        beat(8'hEE, 1'b0);
        beat(8'hFF, 1'b1);
        check("last_at_end_data", 64'(rd_data), 64'hCCDDEEFF);
        check("last_at_end_cnt",  64'(rd_cnt),  64'd4);
        idle();

        // Drain in the same cycle as the completing beat: no HOLD.
        rd_ready = 1'b0;
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b0);
        beat(8'h30, 1'b0);
        beat(8'h40, 1'b0);
        check("sim_first_data", 64'(rd_data), 64'h10203040);
        beat(8'h50, 1'b0);
        beat(8'h60, 1'b0);
        beat(8'h70, 1'b0);
        rd_ready = 1'b1;
        beat(8'h80, 1'b0);
        check("sim_vld",      64'(rd_vld),   64'd1);
        check("sim_data",     64'(rd_data),  64'h50607080);
        check("sim_wr_ready", 64'(wr_ready), 64'd1);
        idle();
        check("sim_drained", 64'(rd_vld), 64'd0);

        // Mid-word reset discards both the buffered word and the partial one.
        rd_ready = 1'b0;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        wr_vld = 1'b0;
        rst    = 1'b1;
        cycle();
        check("mrst_wr_ready", 64'(wr_ready), 64'd0);
        check("mrst_rd_vld",   64'(rd_vld),   64'd0);
        check("mrst_rd_cnt",   64'(rd_cnt),   64'd0);
        check("mrst_rd_data",  64'(rd_data),  64'd0);
        rst      = 1'b0;
        rd_ready = 1'b1;
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        beat(8'h77, 1'b0);
        beat(8'h88, 1'b0);
        check("mrst_after_vld",  64'(rd_vld),  64'd1);
        check("mrst_after_data", 64'(rd_data), 64'h55667788);
        check("mrst_after_cnt",  64'(rd_cnt),  64'd4);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
